stream_topk_tracker: RTL and testbench

Streaming rank tracker that keeps the K largest values seen on an input sample stream, in descending order. Each value is held in a sorted register list with explicit occupancy. The K-th largest value is always visible on a dedicated output. A handshaked dump port serialises the whole list on request. It sits after sample-capture logic in statistics and peak-detection datapaths, where earlier designs only tracked the two largest values with no occupancy or readout.

---
 rtl/stream_topk_tracker.sv | 154 +++++++++++++++
 tb/tb_stream_topk_tracker.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/stream_topk_tracker.sv
// stream_topk_tracker: keeps the K largest samples seen so far in a sorted
// register list, largest first. The K-th largest is always visible on its
// own output. A handshaked dump port reads the whole list out, largest first.
module stream_topk_tracker #(
  parameter int DATA_WIDTH = 8,
  parameter int K          = 4,
  parameter int ALLOW_DUP  = 0
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_in_valid,
  input  logic [DATA_WIDTH-1:0]   i_in_data,
  output logic                    o_in_ready,
  input  logic                    i_clear,
  input  logic                    i_dump_req,
  output logic [DATA_WIDTH-1:0]   o_kth_data,
  output logic                    o_kth_valid,
  output logic [$clog2(K+1)-1:0]  o_occupancy,
  output logic                    o_out_valid,
  input  logic                    i_out_ready,
  output logic [DATA_WIDTH-1:0]   o_out_data,
  output logic [$clog2(K)-1:0]    o_out_rank,
  output logic                    o_out_last
);
  localparam int OW = $clog2(K + 1);
  localparam int RW = $clog2(K);

  typedef enum logic {S_IDLE = 1'b0, S_DUMP = 1'b1} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [DATA_WIDTH-1:0] r_list [K];
  logic [DATA_WIDTH-1:0] w_list_ins [K];
  logic [OW-1:0]         r_occ;
  logic [OW-1:0]         w_occ_next;
  logic [RW-1:0]         r_idx;
  logic [K-1:0]          w_valid;
  logic [K-1:0]          w_above;
  logic [K-1:0]          w_eq;
  logic                  w_flush;
  logic                  w_accept;
  logic                  w_dup_hit;
  logic                  w_insert;
  logic                  w_last;
  logic                  w_beat_done;

  // Per-rank compare against the incoming sample. Because the list is sorted
  // descending, the entries that stay ahead of the sample form a prefix, so
  // the w_above mask is a thermometer code whose length is the insert index.
  generate
    for (genvar gi = 0; gi < K; gi++) begin : g_rank
      assign w_valid[gi] = (OW'(gi) < r_occ);
      assign w_eq[gi]    = w_valid[gi] && (r_list[gi] == i_in_data);
      if (ALLOW_DUP != 0) begin : g_dup
        assign w_above[gi] = w_valid[gi] && (r_list[gi] >= i_in_data);
      end else begin : g_nodup
        assign w_above[gi] = w_valid[gi] && (r_list[gi] > i_in_data);
      end
      // Ahead of the insert point keep, at it take the sample, past it shift down.
      if (gi == 0) begin : g_head
        assign w_list_ins[gi] = w_above[gi] ? r_list[gi] : i_in_data;
      end else begin : g_tail
        assign w_list_ins[gi] = w_above[gi]      ? r_list[gi] :
                                w_above[gi-1]    ? i_in_data  : r_list[gi-1];
      end
    end
  endgenerate

  assign w_flush     = (r_state == S_IDLE) && i_clear;
  assign w_accept    = i_in_valid && o_in_ready;
  assign w_dup_hit   = (ALLOW_DUP == 0) && (|w_eq);
  // A full list whose last entry is still ahead means the insert index is K.
  assign w_insert    = w_accept && !w_dup_hit && !w_above[K-1];
  assign w_occ_next  = w_flush ? '0 :
                       (w_insert && (r_occ != OW'(K))) ? r_occ + OW'(1) : r_occ;
  assign w_last      = ((OW'(r_idx) + OW'(1)) == r_occ);
  assign w_beat_done = (r_state == S_DUMP) && i_out_ready;

  // List storage: flush, or load the shifted/inserted image on an insert.
  generate
    for (genvar gi = 0; gi < K; gi++) begin : g_store
      // One rank register; entries past occupancy stay at zero.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_list[gi] <= '0;
        end else if (w_flush) begin
          r_list[gi] <= '0;
        end else if (w_insert) begin
          r_list[gi] <= w_list_ins[gi];
        end
      end
    end
  endgenerate

  // Occupancy counter, saturating at K.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_occ <= '0;
    end else begin
      r_occ <= w_occ_next;
    end
  end

  // Dump read pointer: advances per handshake, rewinds after the last beat.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx <= '0;
    end else if (w_beat_done) begin
      r_idx <= w_last ? '0 : r_idx + RW'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state: a dump starts only if the list is non-empty after this
  // cycle's update, so a sample accepted alongside dump_req is included.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (i_dump_req && (w_occ_next != '0)) w_state_next = S_DUMP;
      S_DUMP: if (w_beat_done && w_last)            w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // FSM outputs: sample intake in IDLE, dump beat presentation in DUMP.
  always_comb begin
    o_in_ready  = 1'b0;
    o_out_valid = 1'b0;
    o_out_data  = '0;
    o_out_rank  = '0;
    o_out_last  = 1'b0;
    if (r_state == S_IDLE) begin
      o_in_ready = !i_clear;
    end else begin
      o_out_valid = 1'b1;
      o_out_data  = r_list[r_idx];
      o_out_rank  = r_idx;
      o_out_last  = w_last;
    end
  end

  assign o_kth_data  = r_list[K-1];
  assign o_kth_valid = (r_occ == OW'(K));
  assign o_occupancy = r_occ;

endmodule

// File: tb/tb_stream_topk_tracker.sv
// Directed bench for stream_topk_tracker: one instance without duplicates,
// one with duplicates, driven by a linear sequence of steps.
module tb_stream_topk_tracker;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;

  logic       in_valid_a, clear_a, dump_a, out_ready_a;
  logic       in_ready_a, kth_valid_a, out_valid_a, out_last_a;
  logic [7:0] kth_data_a, out_data_a;
  logic [2:0] occ_a;
  logic [1:0] out_rank_a;

  logic       in_valid_b, clear_b, dump_b, out_ready_b;
  logic       in_ready_b, kth_valid_b, out_valid_b, out_last_b;
  logic [7:0] kth_data_b, out_data_b;
  logic [2:0] occ_b;
  logic [1:0] out_rank_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stream_topk_tracker #(.DATA_WIDTH(8), .K(4), .ALLOW_DUP(0)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_in_valid(in_valid_a), .i_in_data(in_data), .o_in_ready(in_ready_a),
    .i_clear(clear_a), .i_dump_req(dump_a),
    .o_kth_data(kth_data_a), .o_kth_valid(kth_valid_a), .o_occupancy(occ_a),
    .o_out_valid(out_valid_a), .i_out_ready(out_ready_a),
    .o_out_data(out_data_a), .o_out_rank(out_rank_a), .o_out_last(out_last_a)
  );

  stream_topk_tracker #(.DATA_WIDTH(8), .K(4), .ALLOW_DUP(1)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_in_valid(in_valid_b), .i_in_data(in_data), .o_in_ready(in_ready_b),
    .i_clear(clear_b), .i_dump_req(dump_b),
    .o_kth_data(kth_data_b), .o_kth_valid(kth_valid_b), .o_occupancy(occ_b),
    .o_out_valid(out_valid_b), .i_out_ready(out_ready_b),
    .o_out_data(out_data_b), .o_out_rank(out_rank_b), .o_out_last(out_last_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int vb[5]   = '{9, 9, 2, 9, 9};
  int ob[5]   = '{1, 2, 3, 4, 4};
  int kb[5]   = '{0, 0, 0, 2, 9};
  int kvb[5]  = '{0, 0, 0, 1, 1};
  int va[6]   = '{5, 9, 3, 9, 7, 1};
  int oa[6]   = '{1, 2, 3, 3, 4, 4};
  int ka[6]   = '{0, 0, 0, 0, 3, 3};
  int kva[6]  = '{0, 0, 0, 0, 1, 1};
  int beat[4] = '{9, 7, 5, 3};

  initial begin
    rst_n = 1'b0; in_data = '0;
    in_valid_a = 0; clear_a = 0; dump_a = 0; out_ready_a = 0;
    in_valid_b = 0; clear_b = 0; dump_b = 0; out_ready_b = 0;
    #1;
    chk("rst_occ", occ_a, 0);
    chk("rst_kth_valid", kth_valid_a, 0);
    chk("rst_kth_data", kth_data_a, 0);
    chk("rst_out_valid", out_valid_a, 0);
    chk("rst_out_data", out_data_a, 0);
    chk("rst_out_last", out_last_a, 0);
    chk("rst_in_ready", in_ready_a, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Duplicate-keeping instance: 9,9,2,9,9 ends as 9,9,9,9.
    for (int i = 0; i < 5; i++) begin
      in_valid_b = 1; in_data = 8'(vb[i]);
      step();
      chk($sformatf("dup_occ[%0d]", i), occ_b, ob[i]);
      chk($sformatf("dup_kth[%0d]", i), kth_data_b, kb[i]);
      chk($sformatf("dup_kv[%0d]", i), kth_valid_b, kvb[i]);
    end
    in_valid_b = 0;
    dump_b = 1;
    step();
    dump_b = 0; out_ready_b = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("dup_beat_data[%0d]", i), out_data_b, 9);
      chk($sformatf("dup_beat_rank[%0d]", i), out_rank_b, i);
      chk($sformatf("dup_beat_last[%0d]", i), out_last_b, (i == 3));
      step();
    end
    chk("dup_dump_end", out_valid_b, 0);
    out_ready_b = 0;

    // Distinct-value instance: 5,9,3,9,7,1 ends as 9,7,5,3.
    for (int i = 0; i < 6; i++) begin
      in_valid_a = 1; in_data = 8'(va[i]);
      step();
      chk($sformatf("occ[%0d]", i), occ_a, oa[i]);
      chk($sformatf("kth[%0d]", i), kth_data_a, ka[i]);
      chk($sformatf("kv[%0d]", i), kth_valid_a, kva[i]);
    end
    in_valid_a = 0;

    // Dump with out_ready toggling; clear/dump_req/in_valid poked during it.
    dump_a = 1;
    #1 chk("in_ready_at_req", in_ready_a, 1);
    step();
    for (int b = 0; b < 4; b++) begin
      clear_a = (b < 2); dump_a = (b < 2); in_valid_a = (b < 2); in_data = 8'd200;
      out_ready_a = 0;
      #1;
      chk($sformatf("beat_valid[%0d]", b), out_valid_a, 1);
      chk($sformatf("beat_data[%0d]", b), out_data_a, beat[b]);
      chk($sformatf("beat_rank[%0d]", b), out_rank_a, b);
      chk($sformatf("beat_last[%0d]", b), out_last_a, (b == 3));
      chk($sformatf("beat_in_ready[%0d]", b), in_ready_a, 0);
      step();
      chk($sformatf("hold_data[%0d]", b), out_data_a, beat[b]);
      chk($sformatf("hold_rank[%0d]", b), out_rank_a, b);
      out_ready_a = 1;
      #1 chk($sformatf("hs_in_ready[%0d]", b), in_ready_a, 0);
      step();
    end
    out_ready_a = 0;
    #1;
    chk("post_dump_valid", out_valid_a, 0);
    chk("post_dump_in_ready", in_ready_a, 1);
    chk("post_dump_occ", occ_a, 4);
    chk("post_dump_kth", kth_data_a, 3);

    // Clear wins over a simultaneous sample.
    in_valid_a = 1; in_data = 8'd8; clear_a = 1;
    #1 chk("clear_in_ready", in_ready_a, 0);
    step();
    in_valid_a = 0; clear_a = 0;
    #1;
    chk("clear_occ", occ_a, 0);
    chk("clear_kv", kth_valid_a, 0);
    chk("clear_kth", kth_data_a, 0);

    // dump_req on an empty list is ignored.
    dump_a = 1;
    step();
    dump_a = 0;
    #1 chk("empty_dump_ignored", out_valid_a, 0);

    // Zero sample accepted with dump_req in the same cycle is dumped.
    in_valid_a = 1; in_data = 8'd0; dump_a = 1;
    step();
    in_valid_a = 0; dump_a = 0; out_ready_a = 1;
    #1;
    chk("zero_valid", out_valid_a, 1);
    chk("zero_occ", occ_a, 1);
    chk("zero_kv", kth_valid_a, 0);
    chk("zero_data", out_data_a, 0);
    chk("zero_rank", out_rank_a, 0);
    chk("zero_last", out_last_a, 1);
    step();
    chk("zero_done_valid", out_valid_a, 0);
    chk("zero_done_in_ready", in_ready_a, 1);

    // Reset during the second dump beat.
    clear_a = 1; out_ready_a = 0;
    step();
    clear_a = 0;
    in_valid_a = 1; in_data = 8'd6;
    step();
    in_data = 8'd4;
    step();
    in_valid_a = 0;
    #1 chk("pre_rst_occ", occ_a, 2);
    dump_a = 1;
    step();
    dump_a = 0; out_ready_a = 1;
    #1 chk("pre_rst_beat0", out_data_a, 6);
    step();
    #1;
    chk("pre_rst_beat1_data", out_data_a, 4);
    chk("pre_rst_beat1_rank", out_rank_a, 1);
    chk("pre_rst_beat1_last", out_last_a, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid_a, 0);
    chk("mid_rst_occ", occ_a, 0);
    chk("mid_rst_out_data", out_data_a, 0);
    chk("mid_rst_out_rank", out_rank_a, 0);
    chk("mid_rst_out_last", out_last_a, 0);
    chk("mid_rst_kth", kth_data_a, 0);
    chk("mid_rst_in_ready", in_ready_a, 1);
    rst_n = 1'b1; out_ready_a = 0;
    step();
    in_valid_a = 1; in_data = 8'd4;
    step();
    in_data = 8'd6;
    step();
    in_valid_a = 0;
    #1;
    chk("fresh_occ", occ_a, 2);
    chk("fresh_kv", kth_valid_a, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
